// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch types, constants and pc helper
package fetch_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Clear the byte-offset bits so every fetch address is instruction aligned.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return addr & ~(XLEN'(INSTR_BYTES - 1));
  endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// rtl/fetch_controller_if.sv - instruction memory, redirect and decode handshake bundle
interface fetch_controller_if;
  import fetch_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_ack, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_ack, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );

endinterface

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - two-entry instruction FIFO with flush
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         do_push;
  logic         do_pop;

  // Guard against underflow/overflow; a pop in the same cycle frees the slot a full push needs.
  assign do_pop  = pop && (count != 2'd0) && !flush;
  assign do_push = push && ((count != 2'd2) || do_pop) && !flush;
  assign head    = mem[rd_ptr];

  // Entry storage needs no reset: an entry is only visible once count covers it.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; flush empties the buffer in one edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - sequential instruction fetch with redirect and 2-entry buffer
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic                clock,
  input  logic                reset,
  fetch_controller_if.master  fetch_bus
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_REQ   = REQ;
  localparam logic [1:0] ST_FLUSH = FLUSH;
  localparam logic [1:0] CAP      = 2'(BUF_DEPTH);

  logic [1:0]      state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] next_pc;
  logic [1:0]      count;
  logic            push;
  logic            pop;
  logic            more_space;
  fetch_entry_t    head;
  fetch_entry_t    push_data;

  assign target    = align_pc(fetch_bus.redirect_pc);
  assign next_pc   = fetch_pc + XLEN'(INSTR_BYTES);

  // A redirect voids any pop handshake and any returning data in the same cycle.
  assign pop       = fetch_bus.instr_valid && fetch_bus.instr_ready && !fetch_bus.redirect_valid;
  assign push      = (state == ST_REQ) && fetch_bus.imem_ack && !fetch_bus.redirect_valid;
  assign push_data = '{pc: fetch_bus.imem_addr, instr: fetch_bus.imem_rdata};

  // Room for another request once this push lands, crediting a same-cycle pop.
  assign more_space = (count + 2'd1 - {1'b0, pop}) < CAP;

  assign fetch_bus.instr_valid = (count != 2'd0);
  assign fetch_bus.instr       = head.instr;
  assign fetch_bus.instr_pc    = head.pc;

  fetch_buffer u_buffer (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (fetch_bus.redirect_valid),
    .head      (head),
    .count     (count)
  );

  // Request FSM: fetch_pc tracks the address being (or about to be) requested.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state              <= ST_IDLE;
      fetch_pc           <= RESET_PC;
      fetch_bus.imem_req  <= 1'b0;
      fetch_bus.imem_addr <= RESET_PC;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fetch_bus.redirect_valid) begin
            fetch_pc            <= target;
            fetch_bus.imem_addr <= target;
            fetch_bus.imem_req  <= 1'b1;
            state               <= ST_REQ;
          end else if (count < CAP) begin
            fetch_bus.imem_addr <= fetch_pc;
            fetch_bus.imem_req  <= 1'b1;
            state               <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (fetch_bus.redirect_valid) begin
            fetch_pc <= target;
            if (fetch_bus.imem_ack) begin
              fetch_bus.imem_addr <= target;
            end else begin
              state <= ST_FLUSH;
            end
          end else if (fetch_bus.imem_ack) begin
            fetch_pc <= next_pc;
            if (more_space) begin
              fetch_bus.imem_addr <= next_pc;
            end else begin
              fetch_bus.imem_req <= 1'b0;
              state              <= ST_IDLE;
            end
          end
        end
        ST_FLUSH: begin
          if (fetch_bus.redirect_valid) fetch_pc <= target;
          if (fetch_bus.imem_ack) begin
            fetch_bus.imem_addr <= fetch_bus.redirect_valid ? target : fetch_pc;
            state               <= ST_REQ;
          end
        end
        default: begin
          fetch_bus.imem_req <= 1'b0;
          state              <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - scoreboard bench for fetch_controller
module tb_fetch_controller;
  import fetch_pkg::*;

  logic clock;
  logic reset;
  fetch_controller_if bus ();

  fetch_controller #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .fetch_bus (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int           vectors     = 0;
  int           miscompares = 0;
  fetch_entry_t exp_q[$];
  fetch_entry_t mon_e;

  bit          auto_ack   = 1'b0;
  bit          rand_delay = 1'b0;
  int          ack_budget = 0;
  int          acks_given = 0;
  int          wait_cnt   = 0;
  int          cur_delay  = 1;
  logic [31:0] hold_addr  = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    fetch_entry_t e;
    e.pc    = pc;
    e.instr = mem_word(pc);
    exp_q.push_back(e);
  endtask

  // One clock; inputs change 1 time unit after the edge. Optional auto memory responder.
  task automatic tick();
    @(posedge clock);
    #1;
    bus.imem_ack = 1'b0;
    if (auto_ack && reset && bus.imem_req) begin
      if (wait_cnt == 0) hold_addr = bus.imem_addr;
      else check("addr_stable", bus.imem_addr, hold_addr);
      wait_cnt++;
      if (wait_cnt >= cur_delay && ack_budget > 0) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = mem_word(bus.imem_addr);
        ack_budget--;
        acks_given++;
        wait_cnt  = 0;
        cur_delay = rand_delay ? int'($urandom_range(5, 1)) : 1;
      end
    end else begin
      wait_cnt = 0;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_req(input logic [31:0] exp_addr);
    int n = 0;
    while (!bus.imem_req && n < 10) begin
      tick();
      n++;
    end
    check("req_rise", bus.imem_req, 1'b1);
    check("req_rise_addr", bus.imem_addr, exp_addr);
  endtask

  // Monitor: every accepted head is compared against the oldest expected entry.
  always @(negedge clock) begin
    if (reset && bus.instr_valid && bus.instr_ready && !bus.redirect_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_instr: got pc %h expected none", bus.instr_pc);
      end else begin
        mon_e = exp_q.pop_front();
        check("instr_pc", bus.instr_pc, mon_e.pc);
        check("instr", bus.instr, mon_e.instr);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset              = 1'b0;
    bus.imem_ack       = 1'b0;
    bus.imem_rdata     = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.instr_ready    = 1'b0;
    ticks(2);
    check("rst_req", bus.imem_req, 1'b0);
    check("rst_addr", bus.imem_addr, 32'h0);
    check("rst_valid", bus.instr_valid, 1'b0);

    // Sequential fetch from reset, decode always ready.
    auto_ack = 1'b1; ack_budget = 4; bus.instr_ready = 1'b1;
    push_exp(32'h0); push_exp(32'h4); push_exp(32'h8); push_exp(32'hC);
    reset = 1'b1;
    tick();
    check("first_req", bus.imem_req, 1'b1);
    check("first_addr", bus.imem_addr, 32'h0);
    ticks(12);
    check("seq_drained", exp_q.size(), 0);
    check("seq_pending_addr", bus.imem_addr, 32'h10);

    // Reset mid-request, then fill the buffer with decode stalled.
    reset = 1'b0;
    #1;
    check("midreq_rst_req", bus.imem_req, 1'b0);
    check("midreq_rst_addr", bus.imem_addr, 32'h0);
    tick();
    bus.instr_ready = 1'b0; ack_budget = 5; acks_given = 0;
    reset = 1'b1;
    ticks(8);
    check("full_acks", acks_given, 2);
    check("full_req_low", bus.imem_req, 1'b0);
    check("full_valid", bus.instr_valid, 1'b1);
    push_exp(32'h0); push_exp(32'h4); push_exp(32'h8); push_exp(32'hC); push_exp(32'h10);
    bus.instr_ready = 1'b1;
    wait_req(32'h8);
    ticks(15);
    check("resume_drained", exp_q.size(), 0);

    // Fill again, then redirect from IDLE.
    bus.instr_ready = 1'b0; ack_budget = 2;
    ticks(8);
    check("refill_req_low", bus.imem_req, 1'b0);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h40;
    tick();
    bus.redirect_valid = 1'b0;
    check("idle_redir_valid", bus.instr_valid, 1'b0);
    check("idle_redir_req", bus.imem_req, 1'b1);
    check("idle_redir_addr", bus.imem_addr, 32'h40);
    ack_budget = 2;
    ticks(8);
    check("full2_req_low", bus.imem_req, 1'b0);

    // Reset with a full buffer.
    reset = 1'b0;
    #1;
    check("fullrst_valid", bus.instr_valid, 1'b0);
    check("fullrst_req", bus.imem_req, 1'b0);
    check("fullrst_addr", bus.imem_addr, 32'h0);
    tick();
    bus.instr_ready = 1'b1; ack_budget = 0;
    reset = 1'b1;
    tick();
    check("post_rst_req", bus.imem_req, 1'b1);
    check("post_rst_addr", bus.imem_addr, 32'h0);
    push_exp(32'h0); push_exp(32'h4);
    ack_budget = 2;
    ticks(8);
    check("pre_redir_drained", exp_q.size(), 0);
    check("pre_redir_addr", bus.imem_addr, 32'h8);

    // Redirect while 0x8 is unacked; ack arrives later and is dropped.
    auto_ack = 1'b0;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h100;
    tick();
    bus.redirect_valid = 1'b0;
    check("flush_hold_addr", bus.imem_addr, 32'h8);
    check("flush_hold_req", bus.imem_req, 1'b1);
    ticks(2);
    bus.imem_ack = 1'b1; bus.imem_rdata = mem_word(32'h8);
    tick();
    check("flush_next_addr", bus.imem_addr, 32'h100);
    check("flush_dropped", bus.instr_valid, 1'b0);
    push_exp(32'h100);
    bus.imem_ack = 1'b1; bus.imem_rdata = mem_word(32'h100);
    tick();
    check("latency_valid", bus.instr_valid, 1'b1);
    check("b2b_addr", bus.imem_addr, 32'h104);
    tick();

    // Redirect to an unaligned target coincident with an ack.
    bus.imem_ack = 1'b1; bus.imem_rdata = mem_word(32'h104);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h203;
    tick();
    bus.redirect_valid = 1'b0;
    check("coinc_addr", bus.imem_addr, 32'h200);
    check("coinc_req", bus.imem_req, 1'b1);
    check("coinc_dropped", bus.instr_valid, 1'b0);

    // Two redirects: second lands in FLUSH and wins; then wrap past 0xFFFF_FFFC.
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h300;
    tick();
    bus.redirect_pc = 32'hFFFF_FFF8;
    tick();
    bus.redirect_valid = 1'b0;
    check("flush2_hold_addr", bus.imem_addr, 32'h200);
    push_exp(32'hFFFF_FFF8); push_exp(32'hFFFF_FFFC); push_exp(32'h0);
    auto_ack = 1'b1; ack_budget = 4;
    ticks(15);
    check("wrap_drained", exp_q.size(), 0);
    check("wrap_pending_addr", bus.imem_addr, 32'h4);

    // Random ack latency and decode back-pressure.
    rand_delay = 1'b1; ack_budget = 20;
    for (int i = 0; i < 20; i++) push_exp(32'h4 + 32'(4 * i));
    for (int i = 0; i < 300; i++) begin
      bus.instr_ready = 1'($urandom_range(1, 0));
      tick();
    end
    bus.instr_ready = 1'b1;
    ticks(20);
    check("rand_drained", exp_q.size(), 0);
    check("rand_pending_addr", bus.imem_addr, 32'h54);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
